path_grant_arbiter: RTL and testbench

PATH_GRANT_ARBITER -- requirements
Module: path_grant_arbiter

---
 rtl/noc_pkg.sv | 21 ++
 rtl/path_select.sv | 44 ++++
 rtl/path_grant_arbiter.sv | 138 +++++++++++++
 tb/tb_path_grant_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh constants, path indices and per-source FSM encoding
package noc_pkg;

    localparam int NUM_PROC = 4;

    localparam logic [2:0] PATH_SELF        = 3'd0;
    localparam logic [2:0] PATH_HORIZ_SHORT = 3'd1;
    localparam logic [2:0] PATH_HORIZ_LONG  = 3'd2;
    localparam logic [2:0] PATH_VERT_SHORT  = 3'd3;
    localparam logic [2:0] PATH_VERT_LONG   = 3'd4;
    localparam logic [2:0] PATH_DIAG_SHORT  = 3'd5;
    localparam logic [2:0] PATH_DIAG_LONG   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } src_state_t;

endpackage

// File: rtl/path_select.sv
// rtl/path_select.sv - maps source/destination and the source's free bits to a path and eligibility
module path_select
    import noc_pkg::*;
(
    input  logic [1:0] src,
    input  logic [1:0] dest,
    input  logic [6:0] free,
    output logic [2:0] path,
    output logic       eligible
);

    logic [1:0] rel;
    logic [2:0] short_path;
    logic [2:0] long_path;

    assign rel = src ^ dest;

    always_comb begin
        short_path = PATH_SELF;
        long_path  = PATH_SELF;
        case (rel)
            2'd1: begin
                short_path = PATH_HORIZ_SHORT;
                long_path  = PATH_HORIZ_LONG;
            end
            2'd2: begin
                short_path = PATH_VERT_SHORT;
                long_path  = PATH_VERT_LONG;
            end
            2'd3: begin
                short_path = PATH_DIAG_SHORT;
                long_path  = PATH_DIAG_LONG;
            end
            default: begin
                short_path = PATH_SELF;
                long_path  = PATH_SELF;
            end
        endcase
        // Long path only when the short one is busy; eligibility follows the chosen path.
        path     = free[short_path] ? short_path : long_path;
        eligible = free[path];
    end

endmodule

// File: rtl/path_grant_arbiter.sv
// rtl/path_grant_arbiter.sv - round-robin path grant arbiter for a 2x2 mesh, one FSM per source
module path_grant_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int LEN_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7*NUM_PROC-1:0]     path_free_bits,
    input  logic [NUM_PROC-1:0]       req_valid,
    input  logic [2*NUM_PROC-1:0]     req_dest,
    input  logic [LEN_W*NUM_PROC-1:0] req_len,
    output logic [NUM_PROC-1:0]       req_ready,
    output logic [NUM_PROC-1:0]       grant_valid,
    output logic [3*NUM_PROC-1:0]     grant_path,
    input  logic [NUM_PROC-1:0]       xfer_beat,
    output logic [NUM_PROC-1:0]       done
);

    src_state_t       state_q [NUM_PROC];
    src_state_t       state_d [NUM_PROC];
    logic [1:0]       dest_q  [NUM_PROC];
    logic [1:0]       dest_d  [NUM_PROC];
    logic [LEN_W-1:0] len_q   [NUM_PROC];
    logic [LEN_W-1:0] len_d   [NUM_PROC];
    logic [LEN_W-1:0] cnt_q   [NUM_PROC];
    logic [LEN_W-1:0] cnt_d   [NUM_PROC];
    logic [2:0]       gpath_q [NUM_PROC];
    logic [2:0]       gpath_d [NUM_PROC];
    logic [2:0]       sel_path[NUM_PROC];

    logic [NUM_PROC-1:0] sel_ok;
    logic [NUM_PROC-1:0] contend;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          winner;
    logic [1:0]          idx;
    logic                cool_q, cool_d;
    logic                grant_any;

    for (genvar g = 0; g < NUM_PROC; g++) begin : g_src
        path_select u_path_select (
            .src      (2'(g)),
            .dest     (dest_q[g]),
            .free     (path_free_bits[7*g +: 7]),
            .path     (sel_path[g]),
            .eligible (sel_ok[g])
        );

        assign contend[g]           = (state_q[g] == ST_WAIT) && sel_ok[g];
        assign req_ready[g]         = (state_q[g] == ST_IDLE);
        assign grant_valid[g]       = (state_q[g] == ST_ACTIVE);
        assign done[g]              = (state_q[g] == ST_DONE);
        assign grant_path[3*g +: 3] = gpath_q[g];
    end

    // The cycle after any grant is blocked: free bits have not yet caught up with the new route.
    always_comb begin
        grant_any = 1'b0;
        winner    = ptr_q;
        idx       = ptr_q;
        for (int i = 0; i < NUM_PROC; i++) begin
            idx = ptr_q + 2'(i);
            if (!cool_q && !grant_any && contend[idx]) begin
                grant_any = 1'b1;
                winner    = idx;
            end
        end
    end

    always_comb begin
        ptr_d  = grant_any ? winner + 2'd1 : ptr_q;
        cool_d = grant_any;
        for (int s = 0; s < NUM_PROC; s++) begin
            state_d[s] = state_q[s];
            dest_d[s]  = dest_q[s];
            len_d[s]   = len_q[s];
            cnt_d[s]   = cnt_q[s];
            gpath_d[s] = gpath_q[s];
            case (state_q[s])
                ST_IDLE: begin
                    if (req_valid[s]) begin
                        dest_d[s]  = req_dest[2*s +: 2];
                        len_d[s]   = req_len[LEN_W*s +: LEN_W];
                        state_d[s] = (req_len[LEN_W*s +: LEN_W] == '0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (grant_any && (winner == 2'(s))) begin
                        state_d[s] = ST_ACTIVE;
                        cnt_d[s]   = len_q[s];
                        gpath_d[s] = sel_path[s];
                    end
                end
                ST_ACTIVE: begin
                    if (xfer_beat[s]) begin
                        cnt_d[s] = cnt_q[s] - LEN_W'(1);
                        if (cnt_q[s] == LEN_W'(1)) begin
                            state_d[s] = ST_DONE;
                            gpath_d[s] = '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_d[s] = ST_IDLE;
                end
                default: begin
                    state_d[s] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            cool_q <= 1'b0;
            for (int s = 0; s < NUM_PROC; s++) begin
                state_q[s] <= ST_IDLE;
                dest_q[s]  <= '0;
                len_q[s]   <= '0;
                cnt_q[s]   <= '0;
                gpath_q[s] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            cool_q <= cool_d;
            for (int s = 0; s < NUM_PROC; s++) begin
                state_q[s] <= state_d[s];
                dest_q[s]  <= dest_d[s];
                len_q[s]   <= len_d[s];
                cnt_q[s]   <= cnt_d[s];
                gpath_q[s] <= gpath_d[s];
            end
        end
    end

endmodule

// File: tb/tb_path_grant_arbiter.sv
// tb/tb_path_grant_arbiter.sv - directed and randomized bench with a behavioural reference model
module tb_path_grant_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [27:0] path_free_bits = '0;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_dest = '0;
    logic [31:0] req_len = '0;
    logic [3:0]  xfer_beat = '0;
    logic [3:0]  req_ready, grant_valid, done;
    logic [11:0] grant_path;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    path_grant_arbiter #(.NUM_PROC(4), .LEN_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .path_free_bits (path_free_bits),
        .req_valid      (req_valid),
        .req_dest       (req_dest),
        .req_len        (req_len),
        .req_ready      (req_ready),
        .grant_valid    (grant_valid),
        .grant_path     (grant_path),
        .xfer_beat      (xfer_beat),
        .done           (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: waiting flag, beats remaining while holding a grant, finish pulse.
    bit m_wait [4];
    int m_left [4];
    bit m_fin  [4];
    int m_dest [4];
    int m_len  [4];
    int m_path [4];
    int m_next;
    bit m_cool;

    function automatic int choose(int s, int d, logic [27:0] fb);
        int rel = s ^ d;
        int sp;
        int lp;
        if (rel == 0) return fb[7*s] ? 0 : -1;
        sp = 2*rel - 1;
        lp = 2*rel;
        if (fb[7*s + sp]) return sp;
        if (fb[7*s + lp]) return lp;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 4; s++) begin
            m_wait[s] = 0; m_left[s] = 0; m_fin[s] = 0;
            m_dest[s] = 0; m_len[s] = 0;  m_path[s] = 0;
        end
        m_next = 0;
        m_cool = 0;
    endtask

    task automatic model_step();
        int win = -1;
        bit ow [4];
        int ol [4];
        bit of [4];
        ow = m_wait; ol = m_left; of = m_fin;
        if (!m_cool) begin
            for (int i = 0; i < 4; i++) begin
                int s = (m_next + i) % 4;
                if (win < 0 && ow[s] && choose(s, m_dest[s], path_free_bits) >= 0) win = s;
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (of[s]) begin
                m_fin[s] = 0;
            end else if (!ow[s] && ol[s] == 0) begin
                if (req_valid[s]) begin
                    m_dest[s] = int'(req_dest[2*s +: 2]);
                    m_len[s]  = int'(req_len[8*s +: 8]);
                    if (m_len[s] == 0) m_fin[s] = 1;
                    else m_wait[s] = 1;
                end
            end else if (ow[s]) begin
                if (s == win) begin
                    m_wait[s] = 0;
                    m_left[s] = m_len[s];
                    m_path[s] = choose(s, m_dest[s], path_free_bits);
                end
            end else if (xfer_beat[s]) begin
                m_left[s] = m_left[s] - 1;
                if (m_left[s] == 0) m_fin[s] = 1;
            end
        end
        m_cool = (win >= 0);
        if (win >= 0) m_next = (win + 1) % 4;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_clear();
        else model_step();
    end

    logic [3:0] prev_gv = '0;
    int cyc = 0;
    int last_rise = -10;

    always @(negedge clock) begin
        logic [3:0]  e_rdy, e_gv, e_dn, rise;
        logic [11:0] e_gp;
        cyc++;
        for (int s = 0; s < 4; s++) begin
            e_rdy[s]       = !m_wait[s] && m_left[s] == 0 && !m_fin[s];
            e_gv[s]        = m_left[s] > 0;
            e_dn[s]        = m_fin[s];
            e_gp[3*s +: 3] = (m_left[s] > 0) ? 3'(m_path[s]) : 3'd0;
        end
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("grant_valid", 32'(grant_valid), 32'(e_gv));
        chk("grant_path", 32'(grant_path), 32'(e_gp));
        chk("done", 32'(done), 32'(e_dn));
        rise = grant_valid & ~prev_gv;
        if (rise != 0) begin
            chk("one_grant_per_cycle", $countones(rise), 1);
            chk("grant_cooldown", 32'(cyc - last_rise > 1), 1);
            last_rise = cyc;
        end
        prev_gv = grant_valid;
    end

    initial begin
        int order[$];
        int when[$];
        logic [3:0] prevg, r;

        repeat (3) @(negedge clock);
        chk("reset_req_ready", 32'(req_ready), 32'hf);
        chk("reset_grant_valid", 32'(grant_valid), 0);
        chk("reset_grant_path", 32'(grant_path), 0);
        chk("reset_done", 32'(done), 0);
        reset = 1'b1;
        @(negedge clock);

        // Self transfer, P0, length 3.
        path_free_bits = '1; req_dest = '0; req_len = 32'd3; req_valid = 4'b0001;
        @(negedge clock); req_valid = '0;
        chk("t1_wait_no_grant", 32'(grant_valid[0]), 0);
        chk("t1_not_ready", 32'(req_ready[0]), 0);
        @(negedge clock);
        chk("t1_grant_valid", 32'(grant_valid[0]), 1);
        chk("t1_grant_path", 32'(grant_path[2:0]), 0);
        xfer_beat = 4'b0001;
        repeat (2) @(negedge clock);
        chk("t1_still_active", 32'(grant_valid[0]), 1);
        chk("t1_no_early_done", 32'(done[0]), 0);
        @(negedge clock);
        chk("t1_done", 32'(done[0]), 1);
        chk("t1_grant_cleared", 32'(grant_valid[0]), 0);
        xfer_beat = '0;
        @(negedge clock);
        chk("t1_done_one_cycle", 32'(done[0]), 0);
        chk("t1_ready_again", 32'(req_ready[0]), 1);

        // Long-path fallback, P1 -> 0 with horizontal short busy.
        path_free_bits = '1; path_free_bits[8] = 1'b0; req_dest = '0;
        req_len = 32'h0000_0100; req_valid = 4'b0010;
        @(negedge clock); req_valid = '0;
        @(negedge clock);
        chk("t2_grant_valid", 32'(grant_valid[1]), 1);
        chk("t2_long_path", 32'(grant_path[5:3]), 2);
        xfer_beat = 4'b0010;
        @(negedge clock);
        chk("t2_done", 32'(done[1]), 1);
        xfer_beat = '0;
        @(negedge clock);

        // Zero length on P2.
        path_free_bits = '1; req_len = '0; req_valid = 4'b0100;
        @(negedge clock); req_valid = '0;
        chk("t3_done", 32'(done[2]), 1);
        chk("t3_no_grant", 32'(grant_valid[2]), 0);
        @(negedge clock);
        chk("t3_done_cleared", 32'(done[2]), 0);

        // Blocked path on P3 -> 1, then release the vertical short.
        path_free_bits = '1; path_free_bits[24] = 1'b0; path_free_bits[25] = 1'b0;
        req_dest = 8'b01_00_00_00; req_len = 32'h0200_0000; req_valid = 4'b1000;
        @(negedge clock); req_valid = '0;
        repeat (3) @(negedge clock);
        chk("t4_blocked", 32'(grant_valid[3]), 0);
        chk("t4_waiting", 32'(req_ready[3]), 0);
        path_free_bits[24] = 1'b1;
        @(negedge clock);
        chk("t4_grant_valid", 32'(grant_valid[3]), 1);
        chk("t4_grant_path", 32'(grant_path[11:9]), 3);
        xfer_beat = 4'b1000;
        repeat (2) @(negedge clock);
        chk("t4_done", 32'(done[3]), 1);
        xfer_beat = '0;
        @(negedge clock);

        // All four request together; pointer is back at P0 after P3's grant.
        path_free_bits = '1; req_dest = 8'b11_10_01_00; req_len = 32'h0101_0101; req_valid = 4'hf;
        @(negedge clock); req_valid = '0; xfer_beat = 4'hf;
        prevg = grant_valid;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            r = grant_valid & ~prevg;
            for (int s = 0; s < 4; s++) begin
                if (r[s]) begin
                    order.push_back(s);
                    when.push_back(c);
                end
            end
            prevg = grant_valid;
        end
        chk("t5_grant_count", order.size(), 4);
        if (order.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t5_order", order[i], i);
            for (int i = 1; i < 4; i++) chk("t5_spacing", when[i] - when[i-1], 2);
        end
        xfer_beat = '0;

        // Reset in the middle of an active burst.
        path_free_bits = '1; req_dest = '0; req_len = 32'd5; req_valid = 4'b0001;
        @(negedge clock); req_valid = '0;
        @(negedge clock);
        chk("t6_active", 32'(grant_valid[0]), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_grant_aborted", 32'(grant_valid), 0);
        chk("t6_ready_all", 32'(req_ready), 32'hf);
        chk("t6_no_done", 32'(done), 0);
        chk("t6_path_cleared", 32'(grant_path), 0);
        @(negedge clock);
        chk("t6_no_done_later", 32'(done), 0);
        reset = 1'b1;
        @(negedge clock);

        repeat (3000) begin
            path_free_bits = 28'($urandom | $urandom);
            req_valid      = 4'($urandom);
            req_dest       = 8'($urandom);
            for (int s = 0; s < 4; s++) req_len[8*s +: 8] = 8'($urandom_range(0, 3));
            xfer_beat      = 4'($urandom);
            @(negedge clock);
        end

        req_valid = '0; xfer_beat = 4'hf; path_free_bits = '1;
        repeat (40) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
